// File: rtl/depuncture_fifo.sv
// Depuncturing FIFO: serial received bits are expanded with erased zero slots
// according to the code rate, buffered with per-slot erase flags, and popped OUT_W at a time.
module depuncture_fifo #(
  parameter int OUT_W = 2,
  parameter int DEPTH = 512
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [1:0]               mode,
  input  logic                     data_in,
  input  logic                     data_in_valid,
  output logic                     data_in_ready,
  output logic [OUT_W-1:0]         data_out,
  output logic [OUT_W-1:0]         erase_out,
  output logic                     data_out_valid,
  input  logic                     data_out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DEPTH-1:0] data_mem;
  logic [DEPTH-1:0] erase_mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [1:0]       phase;
  logic [1:0]       cur_mode;
  logic [1:0]       eff_mode;
  logic [1:0]       rate;
  logic [1:0]       next_phase;
  logic [1:0]       n_slots;
  logic             accept;
  logic             pop;
  logic [LW-1:0]    level_next;
  logic [OUT_W-1:0] rd_data;
  logic [OUT_W-1:0] rd_erase;

  // Room for the worst-case three-slot write keeps the ready decision independent of phase
  assign data_in_ready = (LW'(DEPTH) - level) >= LW'(3);
  assign accept        = data_in_valid && data_in_ready && !flush;
  assign pop           = (level >= LW'(OUT_W)) && (!data_out_valid || data_out_ready);
  // A new mode is only honoured at a pattern boundary
  assign eff_mode      = (phase == 2'd0) ? mode : cur_mode;
  assign rate          = (eff_mode == 2'd3) ? 2'd0 : eff_mode;
  assign level_next    = level + (accept ? LW'(n_slots) : LW'(0)) - (pop ? LW'(OUT_W) : LW'(0));

  always_comb begin
    n_slots    = 2'd1;
    next_phase = phase;
    case (rate)
      2'd1: begin
        next_phase = phase + 2'd1;
        if (phase == 2'd2) begin
          n_slots = 2'd3;
        end else begin
          n_slots = 2'd1;
        end
      end
      2'd2: begin
        if (phase == 2'd2) begin
          next_phase = 2'd0;
          n_slots    = 2'd2;
        end else begin
          next_phase = phase + 2'd1;
          n_slots    = 2'd1;
        end
      end
      default: begin
        next_phase = 2'd0;
        n_slots    = 2'd1;
      end
    endcase
  end

  always_comb begin
    rd_data  = '0;
    rd_erase = '0;
    for (int i = 0; i < OUT_W; i++) begin
      rd_data[i]  = data_mem[rd_ptr + AW'(i)];
      rd_erase[i] = erase_mem[rd_ptr + AW'(i)];
    end
  end

  // Slot storage needs no reset: pointers and level define what is valid
  always_ff @(posedge clock) begin
    if (accept) begin
      data_mem[wr_ptr]  <= data_in;
      erase_mem[wr_ptr] <= 1'b0;
      if (n_slots >= 2'd2) begin
        data_mem[wr_ptr + AW'(1)]  <= 1'b0;
        erase_mem[wr_ptr + AW'(1)] <= 1'b1;
      end
      if (n_slots == 2'd3) begin
        data_mem[wr_ptr + AW'(2)]  <= 1'b0;
        erase_mem[wr_ptr + AW'(2)] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      phase          <= 2'd0;
      cur_mode       <= 2'd0;
      level          <= '0;
      overflow       <= 1'b0;
      data_out       <= '0;
      erase_out      <= '0;
      data_out_valid <= 1'b0;
    end else if (flush) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      phase          <= 2'd0;
      cur_mode       <= 2'd0;
      level          <= '0;
      overflow       <= 1'b0;
      data_out       <= '0;
      erase_out      <= '0;
      data_out_valid <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(n_slots);
        phase  <= next_phase;
        if (phase == 2'd0) begin
          cur_mode <= mode;
        end
      end
      if (data_in_valid && !data_in_ready) begin
        overflow <= 1'b1;
      end
      if (pop) begin
        rd_ptr         <= rd_ptr + AW'(OUT_W);
        data_out       <= rd_data;
        erase_out      <= rd_erase;
        data_out_valid <= 1'b1;
      end else if (data_out_ready) begin
        data_out_valid <= 1'b0;
      end
      level <= level_next;
    end
  end

endmodule

// File: tb/tb_depuncture_fifo.sv
// Self-checking bench for depuncture_fifo (OUT_W=2, DEPTH=16): directed scenarios
// plus randomized traffic compared against a slot-queue reference model.
module tb_depuncture_fifo;

  localparam int OUT_W = 2;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic              clock;
  logic              reset;
  logic              flush;
  logic [1:0]        mode;
  logic              data_in;
  logic              data_in_valid;
  logic              data_in_ready;
  logic [OUT_W-1:0]  data_out;
  logic [OUT_W-1:0]  erase_out;
  logic              data_out_valid;
  logic              data_out_ready;
  logic [LW-1:0]     level;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic d;
    logic e;
  } slot_t;

  // Reference model state
  slot_t            q[$];
  int               m_phase;
  int               m_cm;
  logic             m_valid;
  logic [OUT_W-1:0] m_dout;
  logic [OUT_W-1:0] m_eout;
  logic             m_ov;

  // Words seen handed to the consumer
  logic [OUT_W-1:0] got_d[$];
  logic [OUT_W-1:0] got_e[$];

  depuncture_fifo #(.OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .flush          (flush),
    .mode           (mode),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .erase_out      (erase_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .level          (level),
    .overflow       (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_reset();
    q.delete();
    m_phase = 0;
    m_cm    = 0;
    m_valid = 1'b0;
    m_dout  = '0;
    m_eout  = '0;
    m_ov    = 1'b0;
  endtask

  // One clock edge of the behavioural model, using the inputs presented before the edge
  task automatic model_edge();
    bit    rdy;
    bit    do_pop;
    int    rate;
    int    nz;
    slot_t s;
    if (flush) begin
      model_reset();
    end else begin
      rdy    = (DEPTH - q.size()) >= 3;
      do_pop = (q.size() >= OUT_W) && (!m_valid || data_out_ready);
      if (do_pop) begin
        for (int i = 0; i < OUT_W; i++) begin
          m_dout[i] = q[0].d;
          m_eout[i] = q[0].e;
          void'(q.pop_front());
        end
        m_valid = 1'b1;
      end else if (data_out_ready) begin
        m_valid = 1'b0;
      end
      if (data_in_valid && !rdy) m_ov = 1'b1;
      if (data_in_valid && rdy) begin
        if (m_phase == 0) m_cm = int'(mode);
        rate = (m_cm == 3) ? 0 : m_cm;
        s.d = data_in;
        s.e = 1'b0;
        q.push_back(s);
        nz = 0;
        if (rate == 1 && m_phase == 2) nz = 2;
        if (rate == 2 && m_phase == 2) nz = 1;
        for (int k = 0; k < nz; k++) begin
          s.d = 1'b0;
          s.e = 1'b1;
          q.push_back(s);
        end
        if (rate == 1)      m_phase = (m_phase + 1) % 4;
        else if (rate == 2) m_phase = (m_phase == 2) ? 0 : m_phase + 1;
        else                m_phase = 0;
      end
    end
  endtask

  // Advance one clock: log any handshake, update the model at the edge, settle 1 time unit
  task automatic step();
    if (data_out_valid && data_out_ready) begin
      got_d.push_back(data_out);
      got_e.push_back(erase_out);
    end
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic send(input logic b, input logic [1:0] m);
    data_in       = b;
    mode          = m;
    data_in_valid = 1'b1;
    step();
    data_in_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush         = 1'b1;
    data_in_valid = 1'b0;
    step();
    flush = 1'b0;
    got_d.delete();
    got_e.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (data_out !== 2'b00) begin errors++; $display("FAIL rst_data got %b exp 00", data_out); end
    checks++; if (erase_out !== 2'b00) begin errors++; $display("FAIL rst_erase got %b exp 00", erase_out); end
    checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", data_out_valid); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b exp 0", overflow); end
    checks++; if (data_in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", data_in_ready); end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_rate_half();
    do_flush();
    data_out_ready = 1'b1;
    send(1'b1, 2'd0);
    send(1'b0, 2'd0);
    checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL half_latency_early got %b exp 0", data_out_valid); end
    checks++; if (level !== 5'd2) begin errors++; $display("FAIL half_level got %0d exp 2", level); end
    send(1'b1, 2'd0);
    checks++; if (data_out_valid !== 1'b1) begin errors++; $display("FAIL half_latency got %b exp 1", data_out_valid); end
    send(1'b1, 2'd0);
    repeat (4) step();
    checks++;
    if (got_d.size() != 2) begin
      errors++; $display("FAIL half_count got %0d exp 2", got_d.size());
    end else if (got_d[0] !== 2'b01 || got_e[0] !== 2'b00 || got_d[1] !== 2'b11 || got_e[1] !== 2'b00) begin
      errors++; $display("FAIL half_words got %b/%b %b/%b exp 01/00 11/00", got_d[0], got_e[0], got_d[1], got_e[1]);
    end
  endtask

  task automatic test_rate_3_4();
    logic [1:0] exp_d [3] = '{2'b11, 2'b01, 2'b10};
    logic [1:0] exp_e [3] = '{2'b00, 2'b10, 2'b01};
    do_flush();
    data_out_ready = 1'b1;
    repeat (4) send(1'b1, 2'd1);
    repeat (6) step();
    checks++;
    if (got_d.size() != 3) begin
      errors++; $display("FAIL r34_count got %0d exp 3", got_d.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (got_d[i] !== exp_d[i] || got_e[i] !== exp_e[i]) begin
          errors++; $display("FAIL r34_word%0d got %b/%b exp %b/%b", i, got_d[i], got_e[i], exp_d[i], exp_e[i]);
        end
      end
    end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL r34_level got %0d exp 0", level); end
  endtask

  task automatic test_rate_2_3();
    do_flush();
    data_out_ready = 1'b1;
    send(1'b1, 2'd2);
    send(1'b0, 2'd2);
    send(1'b1, 2'd0);
    repeat (5) step();
    checks++;
    if (got_d.size() != 2) begin
      errors++; $display("FAIL r23_count got %0d exp 2", got_d.size());
    end else if (got_d[0] !== 2'b01 || got_e[0] !== 2'b00 || got_d[1] !== 2'b01 || got_e[1] !== 2'b10) begin
      errors++; $display("FAIL r23_words got %b/%b %b/%b exp 01/00 01/10", got_d[0], got_e[0], got_d[1], got_e[1]);
    end
    send(1'b1, 2'd0);
    step();
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL r23_newmode_level got %0d exp 1", level); end
  endtask

  task automatic test_overflow();
    logic [1:0] first;
    do_flush();
    data_out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      send(1'($urandom_range(0, 1)), 2'd0);
      if (i == 1) first = {data_in, 1'b0};
      if (i == 0) first = 2'b00;
      checks++;
      if (overflow !== m_ov || level !== LW'(q.size())) begin
        errors++; $display("FAIL ovf_step%0d got lvl %0d ov %b exp lvl %0d ov %b", i, level, overflow, q.size(), m_ov);
      end
    end
    checks++; if (level !== 5'd14) begin errors++; $display("FAIL ovf_level got %0d exp 14", level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    checks++; if (data_in_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready got %b exp 0", data_in_ready); end
    checks++; if (data_out_valid !== 1'b1 || data_out !== m_dout) begin
      errors++; $display("FAIL ovf_held got %b/%b exp %b/1", data_out, data_out_valid, m_dout);
    end
  endtask

  task automatic test_flush();
    do_flush();
    data_out_ready = 1'b0;
    repeat (7) send(1'b1, 2'd0);
    checks++; if (level !== 5'd5) begin errors++; $display("FAIL flush_pre_level got %0d exp 5", level); end
    flush         = 1'b1;
    data_in       = 1'b1;
    data_in_valid = 1'b1;
    step();
    flush         = 1'b0;
    data_in_valid = 1'b0;
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL flush_level got %0d exp 0", level); end
    checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", data_out_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL flush_overflow got %b exp 0", overflow); end
    step();
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL flush_stored got %0d exp 0", level); end
  endtask

  task automatic test_async_reset();
    do_flush();
    data_out_ready = 1'b0;
    send(1'b1, 2'd1);
    send(1'b1, 2'd1);
    step();
    checks++; if (data_out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid got %b exp 1", data_out_valid); end
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++; if (data_out_valid !== 1'b0 || data_out !== 2'b00 || erase_out !== 2'b00) begin
      errors++; $display("FAIL arst_outputs got %b/%b/%b exp 0/00/00", data_out_valid, data_out, erase_out);
    end
    checks++; if (level !== 5'd0 || data_in_ready !== 1'b1) begin
      errors++; $display("FAIL arst_level got %0d rdy %b exp 0 rdy 1", level, data_in_ready);
    end
    #1;
    reset = 1'b0;
    model_reset();
    send(1'b1, 2'd1);
    send(1'b0, 2'd1);
    send(1'b1, 2'd1);
    send(1'b1, 2'd1);
    repeat (3) step();
    checks++; if (level !== 5'd4 || data_out_valid !== 1'b1) begin
      errors++; $display("FAIL arst_slots got lvl %0d vld %b exp lvl 4 vld 1", level, data_out_valid);
    end
    checks++; if (data_out !== 2'b01 || erase_out !== 2'b00) begin
      errors++; $display("FAIL arst_word got %b/%b exp 01/00", data_out, erase_out);
    end
  endtask

  task automatic test_random();
    logic [LW-1:0] exp_level;
    logic          exp_rdy;
    do_flush();
    for (int n = 0; n < 1500; n++) begin
      mode           = 2'($urandom_range(0, 3));
      data_in        = 1'($urandom_range(0, 1));
      data_in_valid  = ($urandom_range(0, 9) < 7);
      data_out_ready = ($urandom_range(0, 9) < 5);
      flush          = ($urandom_range(0, 99) == 0);
      step();
      flush     = 1'b0;
      exp_level = LW'(q.size());
      exp_rdy   = (DEPTH - q.size()) >= 3;
      checks++; if (level !== exp_level) begin errors++; $display("FAIL rnd_level cyc %0d got %0d exp %0d", n, level, exp_level); end
      checks++; if (data_in_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", n, data_in_ready, exp_rdy); end
      checks++; if (overflow !== m_ov) begin errors++; $display("FAIL rnd_overflow cyc %0d got %b exp %b", n, overflow, m_ov); end
      checks++; if (data_out_valid !== m_valid) begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", n, data_out_valid, m_valid); end
      if (m_valid) begin
        checks++;
        if (data_out !== m_dout || erase_out !== m_eout) begin
          errors++; $display("FAIL rnd_word cyc %0d got %b/%b exp %b/%b", n, data_out, erase_out, m_dout, m_eout);
        end
      end
    end
  endtask

  initial begin
    reset          = 1'b1;
    flush          = 1'b0;
    mode           = 2'd0;
    data_in        = 1'b0;
    data_in_valid  = 1'b0;
    data_out_ready = 1'b0;
    model_reset();
    test_reset();
    test_rate_half();
    test_rate_3_4();
    test_rate_2_3();
    test_overflow();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
